// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the instruction-fetch refill path.
// This includes the sequencer state, the word size and the line-base helper.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    COMMIT
  } fetch_state_e;

  localparam int WORD_BYTES = 4;

  // Clear the byte and word offset of an address to get its cache-line base.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int offset_bits);
    logic [31:0] mask;
    mask = (32'd1 << (offset_bits + $clog2(WORD_BYTES))) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/refill_beat_counter.sv
// Word-index counter for line refills.
// It has load-to-zero and advance controls, and it flags the last word of a line.
module refill_beat_counter #(
  parameter int OFFSET_BITS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   advance,
  output logic [OFFSET_BITS-1:0] cnt,
  output logic                   last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == {OFFSET_BITS{1'b1}});

endmodule

// File: rtl/fetch_refill_controller.sv
// Instruction-cache miss sequencer. It stalls fetch on a miss and refills the line
// one word per accepted memory beat. It then commits the line tag and counts misses.
module fetch_refill_controller
  import mips_fetch_pkg::*;
#(
  parameter int WORDS_PER_LINE = 4,
  parameter int OFFSET_BITS    = $clog2(WORDS_PER_LINE),
  parameter int MISS_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            pc,
  input  logic                   hit,
  input  logic                   pc_src,
  output logic                   stall,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ready,
  input  logic [31:0]            mem_rdata,
  output logic                   refill_we,
  output logic [OFFSET_BITS-1:0] refill_idx,
  output logic [31:0]            refill_data,
  output logic [31:0]            refill_line,
  output logic                   refill_done,
  output logic [MISS_CNT_W-1:0]  miss_count
);

  fetch_state_e           state, state_nxt;
  logic                   start_miss;
  logic                   beat_adv;
  logic                   beat_last;
  logic [OFFSET_BITS-1:0] cnt;

  refill_beat_counter #(
    .OFFSET_BITS(OFFSET_BITS)
  ) u_beat_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (start_miss),
    .advance(beat_adv),
    .cnt    (cnt),
    .last   (beat_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A redirect beats a miss in IDLE. Once a refill starts, pc_src has no effect
  // because a memory beat sequence cannot be abandoned.
  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    mem_req     = 1'b0;
    refill_done = 1'b0;
    start_miss  = 1'b0;
    case (state)
      IDLE: begin
        if (!hit && !pc_src) begin
          stall      = 1'b1;
          start_miss = 1'b1;
          state_nxt  = FILL;
        end
      end
      FILL: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready && beat_last) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        stall       = 1'b1;
        refill_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign beat_adv = (state == FILL) && mem_ready;
  assign mem_addr = refill_line + 32'({cnt, 2'b00});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill_line <= '0;
      miss_count  <= '0;
    end else if (start_miss) begin
      refill_line <= line_base(pc, OFFSET_BITS);
      if (miss_count != {MISS_CNT_W{1'b1}}) begin
        miss_count <= miss_count + 1'b1;
      end
    end
  end

  // Accepted beats become a one-cycle registered write into the data array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill_we   <= 1'b0;
      refill_idx  <= '0;
      refill_data <= '0;
    end else begin
      refill_we <= beat_adv;
      if (beat_adv) begin
        refill_idx  <= cnt;
        refill_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_refill_controller.sv
// Randomized bench for fetch_refill_controller against a beat-counting reference model.
module tb_fetch_refill_controller;

  localparam int W   = 4;
  localparam int OB  = 2;
  localparam int MCW = 4;

  logic          clk;
  logic          rst_n;
  logic [31:0]   pc;
  logic          hit;
  logic          pc_src;
  logic          stall;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic          refill_we;
  logic [OB-1:0] refill_idx;
  logic [31:0]   refill_data;
  logic [31:0]   refill_line;
  logic          refill_done;
  logic [MCW-1:0] miss_count;

  fetch_refill_controller #(
    .WORDS_PER_LINE(W),
    .MISS_CNT_W    (MCW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc         (pc),
    .hit        (hit),
    .pc_src     (pc_src),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .refill_we  (refill_we),
    .refill_idx (refill_idx),
    .refill_data(refill_data),
    .refill_line(refill_line),
    .refill_done(refill_done),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: a refill is the fetch of W words from the line base in order.
  // The model tracks how many words have been taken and whether a write is pending.
  bit          m_busy;
  int          m_beats;
  logic [31:0] m_base;
  bit          m_wv;
  int          m_widx;
  logic [31:0] m_wdata;
  int          m_miss;

  task automatic model_reset();
    m_busy  = 0;
    m_beats = 0;
    m_base  = 32'h0;
    m_wv    = 0;
    m_widx  = 0;
    m_wdata = 32'h0;
    m_miss  = 0;
  endtask

  task automatic reset_checks();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_refill_we", 32'(refill_we), 32'h0);
    chk("rst_refill_idx", 32'(refill_idx), 32'h0);
    chk("rst_refill_data", refill_data, 32'h0);
    chk("rst_refill_line", refill_line, 32'h0);
    chk("rst_refill_done", 32'(refill_done), 32'h0);
    chk("rst_miss_count", 32'(miss_count), 32'h0);
  endtask

  task automatic step();
    bit fetching;
    @(negedge clk);
    if (!rst_n) begin
      reset_checks();
      model_reset();
    end else begin
      fetching = m_busy && (m_beats < W);
      chk("stall", 32'(stall), m_busy ? 32'h1 : 32'(!hit && !pc_src));
      chk("mem_req", 32'(mem_req), 32'(fetching));
      if (fetching) chk("mem_addr", mem_addr, m_base + 32'(4 * m_beats));
      chk("refill_done", 32'(refill_done), 32'(m_busy && (m_beats == W)));
      chk("refill_we", 32'(refill_we), 32'(m_wv));
      if (m_wv) begin
        chk("refill_idx", 32'(refill_idx), 32'(m_widx));
        chk("refill_data", refill_data, m_wdata);
      end
      chk("refill_line", refill_line, m_base);
      chk("miss_count", 32'(miss_count), 32'(m_miss));

      m_wv = fetching && mem_ready;
      if (m_wv) begin
        m_widx  = m_beats;
        m_wdata = mem_rdata;
      end
      if (!m_busy) begin
        if (!hit && !pc_src) begin
          m_busy  = 1;
          m_beats = 0;
          m_base  = pc & ~32'(4 * W - 1);
          if (m_miss < (1 << MCW) - 1) m_miss++;
        end
      end else if (m_beats == W) begin
        m_busy = 0;
      end else if (mem_ready) begin
        m_beats++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  int saved_miss;

  initial begin
    model_reset();
    rst_n     = 1'b0;
    hit       = 1'b1;
    pc_src    = 1'b0;
    pc        = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;

    // Reset held with hit=1: everything quiet.
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Zero-wait miss at 0x1234.
    pc = 32'h0000_1234;
    hit = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_rdata = $urandom;
      step();
    end
    hit = 1'b1;
    step();
    chk("t2_miss_count", 32'(miss_count), 32'h1);
    chk("t2_line", refill_line, 32'h0000_1230);

    // Slow memory: one beat every third cycle.
    pc = $urandom;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      mem_ready = (k % 3 == 2);
      mem_rdata = $urandom;
      step();
      hit = 1'b1;
    end
    chk("t3_refill_finished", 32'(m_busy), 32'h0);

    // Miss coincident with a redirect is dropped.
    saved_miss = m_miss;
    pc = $urandom;
    hit = 1'b0;
    pc_src = 1'b1;
    step();
    hit = 1'b1;
    pc_src = 1'b0;
    step();
    chk("t4_miss_unchanged", 32'(miss_count), 32'(saved_miss));

    // Redirect in the middle of a refill.
    pc = $urandom;
    hit = 1'b0;
    mem_ready = 1'b1;
    step();
    hit = 1'b1;
    for (int k = 0; k < 12; k++) begin
      pc_src = (k == 2);
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
      step();
    end
    pc_src = 1'b0;

    // Asynchronous reset after the second beat.
    pc = $urandom;
    hit = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_rdata = $urandom;
      step();
    end
    #2;
    rst_n = 1'b0;
    hit = 1'b1;
    #1;
    reset_checks();
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    pc = $urandom;
    hit = 1'b0;
    for (int k = 0; k < 6; k++) begin
      mem_rdata = $urandom;
      step();
    end
    hit = 1'b1;
    step();

    // Random traffic; long enough to saturate the narrow miss counter.
    for (int k = 0; k < 600; k++) begin
      pc        = $urandom;
      hit       = ($urandom_range(0, 1) == 1);
      pc_src    = ($urandom_range(0, 6) == 0);
      mem_ready = ($urandom_range(0, 4) < 3);
      mem_rdata = $urandom;
      step();
    end
    chk("miss_saturated", 32'(miss_count), 32'((1 << MCW) - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
